// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the execute stage and the iterative mul/div unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  // pipeline side: issues ops, consumes results
  modport master (
    output in_valid, funct3, a, b, flush, out_ready,
    input  in_ready, out_valid, result
  );

  // unit side
  modport slave (
    input  in_valid, funct3, a, b, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 shift datapath is shared by
// both operations: a 2*WIDTH accumulator holds {hi, lo} where multiply
// shift-adds into hi while consuming the multiplier from lo, and divide shifts
// the dividend out of lo into hi (remainder) while shifting quotient bits in.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave io
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand |a| or divisor |b|
  logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi, lo} shift register
  logic [WIDTH-1:0]   result_q, result_d;

  // ---- accept-time operand decode ----
  logic             accept, in_is_div;
  logic             a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf;

  // Sign handling and special-case detection on the incoming request
  always_comb begin
    accept    = io.in_valid && !io.flush;
    in_is_div = io.funct3[2];
    a_signed  = (io.funct3 == 3'b001) || (io.funct3 == 3'b010) ||
                (io.funct3 == 3'b100) || (io.funct3 == 3'b110);
    b_signed  = (io.funct3 == 3'b001) || (io.funct3 == 3'b100) ||
                (io.funct3 == 3'b110);
    neg_a     = a_signed && io.a[WIDTH-1];
    neg_b     = b_signed && io.b[WIDTH-1];
    abs_a     = neg_a ? -io.a : io.a;
    abs_b     = neg_b ? -io.b : io.b;
    div_zero  = in_is_div && (io.b == '0);
    // signed DIV/REM overflow: min-neg / -1
    div_ovf   = in_is_div && !io.funct3[0] && (io.a == MIN_NEG) && (io.b == '1);
  end

  // ---- one iteration of the shared shift datapath ----
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // Multiply: conditional add of multiplicand into hi, then shift right.
  // Divide: restoring step, shift left and subtract if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // remainder < divisor bounds the difference below 2^WIDTH when
    // non-negative, so the top bit is a clean borrow flag
    div_ge    = !div_diff[WIDTH];
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end

  // ---- sign fixup and result select ----
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  // Sign flags are only ever set for signed operands, so unsigned ops pass through
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = io.funct3;
          sign_a_d = neg_a;
          sign_b_d = neg_b;
          if (div_zero) begin
            result_d = io.funct3[1] ? io.a : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = io.funct3[1] ? '0 : io.a;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
            if (in_is_div) begin
              opnd_d = abs_b;
              acc_d  = {{WIDTH{1'b0}}, abs_a};
            end else begin
              opnd_d = abs_a;
              acc_d  = {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // flush wins over everything and leaves the last result visible
    if (io.flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide unit, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per handshake and computes it with a shared radix-2 shift datapath over WIDTH cycles. The result is held under a valid/ready handshake until the pipeline takes it. The pipeline stalls EXEC on in_ready low.

Parameters:
WIDTH, 32, operand/result width in bits (>=8).
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept (high only in IDLE)
funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  WIDTH  rs1 operand (dividend / multiplicand)
b  in  WIDTH  rs2 operand (divisor / multiplier)
flush  in  1  synchronous kill of in-flight op
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  WIDTH  selected result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all datapath regs 0. Reset mid-operation discards the op.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: in_ready=1. in_valid&&!flush captures funct3, operand signs and absolute values:
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - MUL uses unsigned magnitudes (low half is sign-agnostic).
- Special cases are decided at accept:
  - DIV*/REM* with b==0: quotient all-ones, remainder = a.
  - Signed DIV/REM with a==min-neg and b==-1: quotient = a, remainder = 0.
  - Either case goes straight to DONE; out_valid is high in cycle T+1 (T = accept cycle).
- Otherwise accept goes to CALC with counter=WIDTH.
- CALC: one iteration per cycle, counter decrements; leaves when counter reaches 0 (exactly WIDTH cycles, T+1..T+WIDTH).
  - Multiply: shift-add into a 2*WIDTH product register.
  - Divide: restoring shift-subtract producing WIDTH-bit quotient and remainder.
- FIXUP (one cycle, T+WIDTH+1):
  - Negate product if sign_a^sign_b (signed operands only).
  - Negate quotient if sign_a^sign_b.
  - Negate remainder if sign_a (signed ops).
  - Select: MUL=low half; MULH/MULHSU/MULHU=high half; DIV*=quotient; REM*=remainder.
  - Register into result.
- DONE: out_valid=1 from T+WIDTH+2. result is stable while out_valid&&!out_ready. out_ready returns to IDLE next cycle, with out_valid=0. No back-to-back accept in the same cycle as drain; next accept is earliest in the following cycle.
- Latency: normal op WIDTH+2 cycles accept-to-valid (34 at WIDTH=32); special cases 1 cycle.
- flush: in any state, next state=IDLE, out_valid=0; result retains its last value.
  - flush with in_valid in IDLE: request not accepted.
  - flush has priority over out_ready and over accept.
- in_valid while not IDLE is ignored (in_ready=0). Operands need not be held after the accept cycle.
- All arithmetic is modulo 2^WIDTH. Negation is two's complement. Product register is 2*WIDTH wide.

Test Plan:
1. Reset: rst_n low mid-CALC -> out_valid=0, in_ready=1 immediately (async). After release, MUL 7*0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 34 cycles after accept.
2. High multiplies:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. Signed divide: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
4. Corner cases, each with out_valid 1 cycle after accept:
   - DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Backpressure/flush:
   - Hold out_ready=0 for 10 cycles -> result/out_valid stable.
   - Then pulse out_ready -> IDLE next cycle.
   - flush at CALC cycle 5 -> IDLE next cycle, no out_valid; following MUL 3*4 -> 12.
6. Random sweep at WIDTH=32 and WIDTH=16, all funct3, against a golden model, random out_ready/flush.
